// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller.
// Contents: data/address widths, request size encodings, FSM state type.
package mem_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the memory access controller.
// Ports:
//   old_word   in  32  word read from memory
//   wdata      in  32  right-justified store data
//   offset     in  2   byte offset within the word (little-endian lanes)
//   size       in  2   byte / half / word
//   is_uns     in  1   zero-extend loads when 1, sign-extend when 0
//   load_data  out 32  extracted and extended load value
//   merged     out 32  old_word with the store lane(s) replaced by wdata
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_uns,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = old_word[{offset, 3'b000} +: 8];
        half_sel  = old_word[{offset[1], 4'b0000} +: 16];
        load_data = old_word;
        merged    = old_word;
        case (size)
            SZ_BYTE: begin
                load_data = is_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = is_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = old_word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the word-organised main memory port.
// Takes byte/half/word load/store requests over valid/ready, runs them against
// memory (read-modify-write for sub-word stores) and returns a one-cycle response.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_write/size/unsigned/addr/wdata   request fields
//   resp_valid/resp_rdata/resp_err       one-cycle completion
//   dira/write_data/memwrite/memread     memory command side
//   mem_rdata                     memory read data, valid RD_LAT cycles after memread rises
//
// state    | meaning
// ST_IDLE  | ready for a request; strobes low, dira/write_data hold
// ST_READ  | memread high for RD_LAT+1 cycles, capture on the last one
// ST_WRITE | memwrite high for one cycle
// ST_RESP  | resp_valid pulse
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dira,
    output logic [DATA_W-1:0] write_data,
    output logic              memwrite,
    output logic              memread,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                lat_write, lat_uns;
    logic [1:0]          lat_size, lat_off;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata_q, wdata_q;
    logic [ADDR_W-1:0]   dira_q;
    logic                err_q;
    logic                accept, bad, rd_last, word_store;
    logic [DATA_W-1:0]   load_data, merged;

    assign accept     = req_valid && req_ready;
    assign word_store = req_write && (req_size == SZ_WORD);
    assign bad        = (req_size == SZ_ILL)
                      | ((req_size == SZ_HALF) & req_addr[0])
                      | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                      | (|req_addr[31:29]);
    assign rd_last    = (state == ST_READ) && (cnt == CNT_LAST);

    // Gate with rst so nothing is offered or strobed while reset is held.
    assign req_ready  = (state == ST_IDLE)  && !rst;
    assign memread    = (state == ST_READ)  && !rst;
    assign memwrite   = (state == ST_WRITE) && !rst;
    assign resp_valid = (state == ST_RESP)  && !rst;

    // rdata_q/err_q are only loaded on entry to RESP and cleared otherwise,
    // so they read as 0 outside the response cycle.
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dira       = dira_q;
    assign write_data = wdata_q;

    mem_lane_align u_align (
        .old_word  (mem_rdata),
        .wdata     (lat_wdata),
        .offset    (lat_off),
        .size      (lat_size),
        .is_uns    (lat_uns),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bad)             state_nxt = ST_RESP;
                    else if (word_store) state_nxt = ST_WRITE;
                    else                 state_nxt = ST_READ;
                end
            end
            ST_READ:  if (rd_last) state_nxt = lat_write ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'b00;
            lat_off   <= 2'b00;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            dira_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= (state == ST_READ) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                lat_write <= req_write;
                lat_uns   <= req_unsigned;
                lat_size  <= req_size;
                lat_off   <= req_addr[1:0];
                lat_wdata <= req_wdata;
                if (bad) begin
                    err_q <= 1'b1;
                end else begin
                    dira_q <= req_addr[28:2];
                    if (word_store) wdata_q <= req_wdata;
                end
            end
            if (rd_last) begin
                if (lat_write) wdata_q <= merged;
                else           rdata_q <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances (RD_LAT 0, 1, 3), each
// with its own small word memory that only returns valid data RD_LAT cycles
// after memread rises.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int LATS [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid_a;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic [2:0]  req_ready_a, resp_valid_a, resp_err_a, memwrite_a, memread_a;
    logic [31:0] resp_rdata_a [3];
    logic [26:0] dira_a [3];
    logic [31:0] write_data_a [3];
    logic [31:0] mem_rdata_a [3];

    logic [31:0] mem [3][16];
    logic [3:0]  rcnt [3];
    logic        bd_we;
    int          bd_sel;
    logic [3:0]  bd_addr;
    logic [31:0] bd_data;

    int n_err = 0;
    int n_chk = 0;

    // per-request observations
    int          r_resp, r_rd, r_wr, r_wr_cyc;
    logic [26:0] r_wr_dira;
    logic [31:0] r_wr_data, r_rdata;
    logic        r_err, r_both, r_ready1;

    always #5 clk = ~clk;

    mem_access_ctrl #(.RD_LAT(0)) dut_l0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a[0]),
        .resp_rdata(resp_rdata_a[0]), .resp_err(resp_err_a[0]), .dira(dira_a[0]),
        .write_data(write_data_a[0]), .memwrite(memwrite_a[0]), .memread(memread_a[0]),
        .mem_rdata(mem_rdata_a[0]));

    mem_access_ctrl #(.RD_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a[1]),
        .resp_rdata(resp_rdata_a[1]), .resp_err(resp_err_a[1]), .dira(dira_a[1]),
        .write_data(write_data_a[1]), .memwrite(memwrite_a[1]), .memread(memread_a[1]),
        .mem_rdata(mem_rdata_a[1]));

    mem_access_ctrl #(.RD_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a[2]),
        .resp_rdata(resp_rdata_a[2]), .resp_err(resp_err_a[2]), .dira(dira_a[2]),
        .write_data(write_data_a[2]), .memwrite(memwrite_a[2]), .memread(memread_a[2]),
        .mem_rdata(mem_rdata_a[2]));

    // Memory models: writes on memwrite, backdoor preload, read-latency counter.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            rcnt[k] <= memread_a[k] ? rcnt[k] + 4'd1 : 4'd0;
            if (memwrite_a[k])
                mem[k][dira_a[k][3:0]] <= write_data_a[k];
            else if (bd_we && bd_sel == k)
                mem[k][bd_addr] <= bd_data;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mem_rdata_a[k] = 32'hBAD0_BAD0;
            if (memread_a[k] && rcnt[k] == 4'(LATS[k]))
                mem_rdata_a[k] = mem[k][dira_a[k][3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bd_wr(input int k, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_sel = k; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issues one request to instance k and records what happens, cycle by
    // cycle relative to the accept cycle c (cycle numbers are offsets from c).
    task automatic run_req(input int k, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        bit done = 0;
        r_resp = -1; r_rd = 0; r_wr = 0; r_wr_cyc = -1; r_wr_dira = '0; r_wr_data = '0;
        r_rdata = '1; r_err = 1'b0; r_both = 1'b0; r_ready1 = 1'b1;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid_a[k] = 1'b1;
        chk("ready_before_req", {31'd0, req_ready_a[k]}, 32'd1);
        @(negedge clk);
        req_valid_a[k] = 1'b0;
        r_ready1 = req_ready_a[k];
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            if (memread_a[k]) r_rd++;
            if (memwrite_a[k]) begin
                r_wr++;
                if (r_wr_cyc < 0) r_wr_cyc = cyc;
                r_wr_dira = dira_a[k];
                r_wr_data = write_data_a[k];
            end
            if (memread_a[k] && memwrite_a[k]) r_both = 1'b1;
            if (resp_valid_a[k]) begin
                r_resp = cyc; r_rdata = resp_rdata_a[k]; r_err = resp_err_a[k]; done = 1;
            end
            if (!done) @(negedge clk);
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    int mid_wr, mid_resp;

    initial begin
        rst = 1'b1; bd_we = 1'b0; bd_sel = 0; bd_addr = '0; bd_data = '0;
        req_valid_a = '0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ready", {31'd0, req_ready_a[1]}, 32'd0);
        chk("rst_strobes", {29'd0, memread_a[1], memwrite_a[1], resp_valid_a[1]}, 32'd0);
        chk("rst_dira", {5'd0, dira_a[1]}, 32'd0);
        chk("rst_wdata", write_data_a[1], 32'd0);
        chk("rst_resp", {resp_rdata_a[1][30:0], resp_err_a[1]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready_a[1]}, 32'd1);

        // word store then load, RD_LAT=1
        run_req(1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("wst_ready_drop", {31'd0, r_ready1}, 32'd0);
        chk("wst_wr_cyc", r_wr_cyc, 32'd1);
        chk("wst_dira", {5'd0, r_wr_dira}, 32'd4);
        chk("wst_wdata", r_wr_data, 32'hDEAD_BEEF);
        chk("wst_resp_cyc", r_resp, 32'd2);
        chk("wst_counts", {r_rd[15:0], r_wr[15:0]}, {16'd0, 16'd1});
        chk("wst_resp", {r_rdata[30:0], r_err}, 32'd0);
        chk("wst_mem", mem[1][4], 32'hDEAD_BEEF);
        run_req(1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0);
        chk("wld_resp_cyc", r_resp, 32'd3);
        chk("wld_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("wld_rd_cycles", r_rd, 32'd2);

        // byte store RMW over 0x11223344; upper wdata bits must be ignored
        bd_wr(1, 4'd4, 32'h1122_3344);
        run_req(1, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h1234_56AB);
        chk("bst_wr_cyc", r_wr_cyc, 32'd3);
        chk("bst_resp_cyc", r_resp, 32'd4);
        chk("bst_wdata", r_wr_data, 32'hAB22_3344);
        chk("bst_no_overlap", {31'd0, r_both}, 32'd0);
        chk("bst_mem", mem[1][4], 32'hAB22_3344);
        run_req(1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0);
        chk("bld_signed", r_rdata, 32'hFFFF_FFAB);
        run_req(1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0);
        chk("bld_unsigned", r_rdata, 32'h0000_00AB);

        // halfword lanes
        bd_wr(1, 4'd4, 32'h8001_1234);
        run_req(1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0);
        chk("hld_signed", r_rdata, 32'hFFFF_8001);
        run_req(1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0);
        chk("hld_unsigned", r_rdata, 32'h0000_8001);
        run_req(1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0010, 32'h0);
        chk("hld_low", r_rdata, 32'h0000_1234);
        run_req(1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h0);
        chk("bld_lane1", r_rdata, 32'h0000_0012);
        run_req(1, 1'b1, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0000_CAFE);
        chk("hst_mem", mem[1][4], 32'hCAFE_1234);

        // error cases: no strobes, response in c+1
        run_req(1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0011, 32'h0);
        chk("err_half_mis", {r_resp[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        chk("err_half_strobes", r_rd + r_wr, 32'd0);
        chk("err_half_rdata", r_rdata, 32'd0);
        run_req(1, 1'b1, SZ_WORD, 1'b0, 32'h2000_0000, 32'hFFFF_FFFF);
        chk("err_range", {r_resp[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        chk("err_range_strobes", r_rd + r_wr, 32'd0);
        run_req(1, 1'b0, SZ_ILL, 1'b0, 32'h0000_0010, 32'h0);
        chk("err_size", {r_resp[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        chk("err_size_rdata", r_rdata, 32'd0);
        run_req(1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0012, 32'h0);
        chk("err_word_mis", {r_resp[15:0], 15'd0, r_err}, {16'd1, 16'd1});
        chk("err_mem_kept", mem[1][4], 32'hCAFE_1234);

        // reset during READ of a sub-word store
        bd_wr(1, 4'd5, 32'h5566_7788);
        @(negedge clk);
        req_write = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = 32'h0000_0014; req_wdata = 32'h0000_00EE; req_valid_a[1] = 1'b1;
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        chk("mid_in_read", {31'd0, memread_a[1]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", {31'd0, req_ready_a[1]}, 32'd1);
        mid_wr = 0; mid_resp = 0;
        for (int i = 0; i < 6; i++) begin
            if (memwrite_a[1]) mid_wr++;
            if (resp_valid_a[1]) mid_resp++;
            @(negedge clk);
        end
        chk("mid_no_activity", {mid_wr[15:0], mid_resp[15:0]}, 32'd0);
        chk("mid_mem_kept", mem[1][5], 32'h5566_7788);

        // read latency sweep
        bd_wr(0, 4'd2, 32'h0BAD_F00D);
        bd_wr(2, 4'd2, 32'h0BAD_F00D);
        run_req(0, 1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0);
        chk("lat0_resp_cyc", r_resp, 32'd2);
        chk("lat0_rd_cycles", r_rd, 32'd1);
        chk("lat0_rdata", r_rdata, 32'h0BAD_F00D);
        run_req(2, 1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0);
        chk("lat3_resp_cyc", r_resp, 32'd5);
        chk("lat3_rd_cycles", r_rd, 32'd4);
        chk("lat3_rdata", r_rdata, 32'h0BAD_F00D);
        run_req(2, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0009, 32'h0000_005A);
        chk("lat3_bst_wr_cyc", r_wr_cyc, 32'd5);
        chk("lat3_bst_resp_cyc", r_resp, 32'd6);
        chk("lat3_bst_mem", mem[2][2], 32'h0BAD_5A0D);
        run_req(0, 1'b1, SZ_HALF, 1'b0, 32'h0000_000A, 32'h0000_7777);
        chk("lat0_hst_resp_cyc", r_resp, 32'd3);
        chk("lat0_hst_mem", mem[0][2], 32'h7777_F00D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator side of the word-organised main memory port. Accepts byte/halfword/word load and store requests from the CPU datapath over a valid/ready handshake. Drives the memory's `dira`/`write_data`/`memwrite`/`memread` inputs and captures its read data. Performs sign/zero extension for loads, read-modify-write for sub-word stores, and alignment/range checking.

## Interface
Parameters:
- `RD_LAT`, 1: cycles from the first `memread` cycle until `mem_rdata` is valid (0 means combinational read).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller can accept a request (IDLE only).
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified for sub-word sizes.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal size, or out-of-range; valid with `resp_valid`.
- `dira`  out  27  memory word address = `req_addr[28:2]`.
- `write_data`  out  32  memory write word.
- `memwrite`  out  1  memory write strobe.
- `memread`  out  1  memory read strobe.
- `mem_rdata`  in  32  memory read data.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, latch all request fields, then check:
  - error if `req_size`=11;
  - error if half with `addr[0]`=1, or word with `addr[1:0]`≠0;
  - error if `addr[31:29]`≠0.
- Error: go to RESP with `resp_err`=1. No memory strobe is issued.
- Word store: go to WRITE. Load or sub-word store: go to READ.
- READ: `memread`=1 and `dira` stable for RD_LAT+1 cycles; cycle counter runs 0..RD_LAT. Capture `mem_rdata` when the counter equals RD_LAT.
  - Load: extract the lane, extend it, go to RESP.
  - Sub-word store: merge `req_wdata` into the captured word, go to WRITE.
- Byte lanes are little-endian: `addr[1:0]`=0 selects bits [7:0]; half at `addr[1]`=1 selects bits [31:16].
- WRITE: `memwrite`=1 for exactly one cycle with `dira` and `write_data` driven, then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE. There is no response backpressure; the CPU must sample in that cycle.
- `memread` and `memwrite` are never both 1. When idle, both strobes are 0 and `dira`/`write_data` hold their last values.

## Timing
- Request accepted in cycle c.
- Load: READ in c+1..c+1+RD_LAT, `resp_valid` in c+2+RD_LAT (RD_LAT=1 gives c+3).
- Word store: `memwrite` in c+1, `resp_valid` in c+2.
- Sub-word store: READ in c+1..c+1+RD_LAT, `memwrite` in c+2+RD_LAT, `resp_valid` in c+3+RD_LAT.
- Error: `resp_valid` in c+1.
- `req_ready` falls the cycle after acceptance and returns in the cycle after RESP, so there are no back-to-back accepts.
- Reset values: `req_ready`=0 while `rst`=1 and 1 in the first cycle after; all other outputs 0; state IDLE.
- `rst` mid-operation: next cycle is IDLE with strobes 0. An aborted RMW performs no write and produces no response.
- `req_valid` while not ready is ignored; the CPU holds the request.

## Structure
- Package `mem_pkg`:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum;
  - `ADDR_W`=27, `DATA_W`=32.
- Sub-module `mem_lane_align` (combinational): load lane extract with sign/zero extension, and store merge of `req_wdata` into the old word by `addr[1:0]` and size.
- The FSM, counter and request latches live in `mem_access_ctrl`.

## Test plan
- Word store then load, RD_LAT=1: store 0xDEADBEEF at 0x0000_0010 → `dira`=4 and `memwrite` pulse in c+1; load gives `resp_rdata`=0xDEADBEEF at c+3.
- Byte store 0xAB at 0x0000_0013 over word 0x11223344 → read, then write 0xAB223344. Signed byte load gives 0xFFFFFFAB; unsigned gives 0x000000AB.
- Half at 0x0000_0012 holding 0x8001: signed load gives 0xFFFF8001, unsigned gives 0x00008001. Half at 0x0000_0011 gives `resp_err`=1 at c+1 with no strobes.
- Out-of-range 0x2000_0000 and `req_size`=11 → `resp_err`=1, `resp_rdata`=0, `memread`/`memwrite` never asserted.
- Assert `rst` during READ of a sub-word store → no `memwrite`, no `resp_valid`, `req_ready`=1 in the cycle after reset deasserts; memory word unchanged.
- RD_LAT=0 and RD_LAT=3 sweeps → load response at c+2+RD_LAT; `memread` held exactly RD_LAT+1 cycles.
